// File: rtl/timer_counter.sv
// 8-bit up/down timer counter with internal clock prescaler and parallel load from TDR.
// Optional build macro TIMER_RELOAD_EN: a wrap reloads tcnt from tdr instead of 0/MAX.
module timer_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       clk_sel,
    input  logic [7:0]       tcr,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
    output logic [WIDTH-1:0] tcnt,
    output logic             ovf,
    output logic             undf
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic             en;
    logic             dir;
    logic             unused_tcr;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_mask;
    logic             tick;
    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic [WIDTH-1:0] wrap_up, wrap_dn;
    logic             ovf_q, ovf_d;
    logic             undf_q, undf_d;

    assign en         = tcr[4];
    assign dir        = tcr[5];
    assign unused_tcr = ^{tcr[7:6], tcr[3:0]};

    // A tick fires when the low clk_sel+1 prescaler bits are all ones.
    always_comb begin
        psc_mask = '0;
        case (clk_sel)
            2'd0:    psc_mask = PSC_W'(4'h1);
            2'd1:    psc_mask = PSC_W'(4'h3);
            2'd2:    psc_mask = PSC_W'(4'h7);
            default: psc_mask = PSC_W'(4'hF);
        endcase
    end

    assign tick  = en && ((psc_q & psc_mask) == psc_mask);
    assign psc_d = en ? psc_q + PSC_W'(1) : '0;

`ifdef TIMER_RELOAD_EN
    assign wrap_up = tdr;
    assign wrap_dn = tdr;
`else
    assign wrap_up = '0;
    assign wrap_dn = MAX;
`endif

    always_comb begin
        tcnt_d = tcnt_q;
        ovf_d  = 1'b0;
        undf_d = 1'b0;
        if (load) begin
            tcnt_d = tdr;
        end else if (tick && !dir) begin
            if (tcnt_q == MAX) begin
                tcnt_d = wrap_up;
                ovf_d  = 1'b1;
            end else begin
                tcnt_d = tcnt_q + WIDTH'(1);
            end
        end else if (tick && dir) begin
            if (tcnt_q == '0) begin
                tcnt_d = wrap_dn;
                undf_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q  <= '0;
            tcnt_q <= '0;
            ovf_q  <= 1'b0;
            undf_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            tcnt_q <= tcnt_d;
            ovf_q  <= ovf_d;
            undf_q <= undf_d;
        end
    end

    assign tcnt = tcnt_q;
    assign ovf  = ovf_q;
    assign undf = undf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expected states are queued as stimulus is driven.
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] clk_sel;
    logic [7:0] tcr;
    logic       load;
    logic [7:0] tdr;
    logic [7:0] tcnt;
    logic       ovf;
    logic       undf;

`ifdef TIMER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    typedef struct {
        logic [7:0] tcnt;
        logic       ovf;
        logic       undf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    timer_counter #(.WIDTH(8), .PSC_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_sel (clk_sel),
        .tcr     (tcr),
        .load    (load),
        .tdr     (tdr),
        .tcnt    (tcnt),
        .ovf     (ovf),
        .undf    (undf)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] t, input logic o, input logic u);
        exp_t e;
        e.tcnt = t;
        e.ovf  = o;
        e.undf = u;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] v);
        tdr  = v;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0; tcr = 8'h10; load = 1'b1; tdr = 8'hAA; clk_sel = 2'd0;
        push(8'h00, 1'b0, 1'b0);
        cyc(3);
        e = sb.pop_front();
        checks++;
        if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
            errors++;
            $display("FAIL reset_hold: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                     tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
        end
        load = 1'b0; tcr = 8'h00;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_up_ovf;
        exp_t       e;
        logic [7:0] w;
        tcr = 8'h00; clk_sel = 2'd0;
        do_load(8'hFE);
        w = RELOAD ? 8'hFE : 8'h00;
        tcr = 8'h10;
        push(8'hFE, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        push(w,     1'b1, 1'b0);
        push(w,     1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            e = sb.pop_front();
            checks++;
            if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
                errors++;
                $display("FAIL up_ovf c%0d: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                         i + 1, tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
            end
        end
        tcr = 8'h00;
        cyc(1);
    endtask

    task automatic test_down_undf;
        exp_t       e;
        logic [7:0] w;
        tcr = 8'h20; clk_sel = 2'd3;
        do_load(8'h01);
        w = RELOAD ? 8'h01 : 8'hFF;
        tcr = 8'h30;
        for (int k = 1; k <= 33; k++) begin
            if (k < 16)       push(8'h01, 1'b0, 1'b0);
            else if (k < 32)  push(8'h00, 1'b0, 1'b0);
            else if (k == 32) push(w,     1'b0, 1'b1);
            else              push(w,     1'b0, 1'b0);
        end
        for (int k = 1; k <= 33; k++) begin
            cyc(1);
            e = sb.pop_front();
            checks++;
            if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
                errors++;
                $display("FAIL down_undf c%0d: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                         k, tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
            end
        end
        tcr = 8'h00;
        cyc(1);
    endtask

    task automatic test_psc_select;
        exp_t e;
        tcr = 8'h00;
        do_load(8'h00);
        clk_sel = 2'd2; tcr = 8'h10;
        push(8'h08, 1'b0, 1'b0);
        cyc(64);
        e = sb.pop_front();
        checks++;
        if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
            errors++;
            $display("FAIL psc_div8: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                     tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
        end
        clk_sel = 2'd1;
        push(8'h08, 1'b0, 1'b0);
        push(8'h10, 1'b0, 1'b0);
        cyc(3);
        e = sb.pop_front();
        checks++;
        if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
            errors++;
            $display("FAIL psc_switch: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                     tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
        end
        cyc(29);
        e = sb.pop_front();
        checks++;
        if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
            errors++;
            $display("FAIL psc_div4: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                     tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
        end
        tcr = 8'h00;
        cyc(1);
    endtask

    task automatic test_load_collision;
        exp_t e;
        tcr = 8'h00; clk_sel = 2'd0;
        do_load(8'hFF);
        tcr = 8'h10;
        cyc(1);
        tdr = 8'h80; load = 1'b1;
        push(8'h80, 1'b0, 1'b0);
        push(8'h80, 1'b0, 1'b0);
        push(8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            load = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
                errors++;
                $display("FAIL load_collide c%0d: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                         i + 1, tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
            end
        end
        tcr = 8'h00;
        cyc(1);
    endtask

    task automatic test_enable_gating;
        exp_t       e;
        logic [7:0] w;
        tcr = 8'h00; clk_sel = 2'd0;
        do_load(8'hFF);
        tdr = 8'hF0;
        w = RELOAD ? 8'hF0 : 8'h00;
        push(8'hFF, 1'b0, 1'b0);
        push(w,     1'b1, 1'b0);
        push(w,     1'b0, 1'b0);
        for (int i = 0; i < 10; i++) push(w, 1'b0, 1'b0);
        push(w,           1'b0, 1'b0);
        push(w + 8'h01,   1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            if (i == 0)  tcr = 8'h10;
            if (i == 3)  tcr = 8'h00;
            if (i == 13) tcr = 8'h10;
            cyc(1);
            e = sb.pop_front();
            checks++;
            if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
                errors++;
                $display("FAIL en_gate c%0d: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                         i + 1, tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
            end
        end
        tcr = 8'h00;
        cyc(1);
    endtask

    task automatic test_async_reset_midcount;
        exp_t e;
        tcr = 8'h00; clk_sel = 2'd0;
        do_load(8'h37);
        tcr = 8'h10;
        cyc(1);
        push(8'h37, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
            errors++;
            $display("FAIL rst_pre: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                     tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
        end
        #2 rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        checks++;
        if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
            errors++;
            $display("FAIL rst_async: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                     tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
        end
        cyc(1);
        rst_n = 1'b1;
        push(8'h00, 1'b0, 1'b0);
        push(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            e = sb.pop_front();
            checks++;
            if ({tcnt, ovf, undf} !== {e.tcnt, e.ovf, e.undf}) begin
                errors++;
                $display("FAIL rst_release c%0d: got tcnt=%h ovf=%b undf=%b want tcnt=%h ovf=%b undf=%b",
                         i + 1, tcnt, ovf, undf, e.tcnt, e.ovf, e.undf);
            end
        end
        tcr = 8'h00;
        cyc(1);
    endtask

    initial begin
        rst_n = 1'b0; clk_sel = 2'd0; tcr = 8'h00; load = 1'b0; tdr = 8'h00;
        test_reset();
        test_up_ovf();
        test_down_undf();
        test_psc_select();
        test_load_collision();
        test_enable_gating();
        test_async_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
